sseg_scan_scheduler: RTL
========================

# sseg_scan_scheduler

Time-multiplexing controller for the 8-digit seven-segment display. Holds a committed 32-bit hex value plus per-digit decimal-point and enable masks, and scans one digit at a time at a programmable refresh rate. Drives the digit-select, nibble and decimal-point inputs of the seven-segment driver. New values arrive through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of two values.

## Interface

Parameters:
- DIGITS, 8, number of scanned digits (2..8); digit i shows value[4i+3:4i]
- REFRESH_DIV, 100000, clk cycles per digit slot (>= 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  requester presents a new display image
- load_ready  output  1  scheduler can accept an image
- value  input  32  hex value, nibble i for digit i
- dp_mask  input  8  decimal point on for digit i when bit i = 1
- digit_en  input  8  digit i lit when bit i = 1
- blank_lz  input  1  leading-zero blanking enable
- active_digit  output  3  index of the currently scanned digit
- num  output  4  nibble for active_digit
- dp_ctrl  output  1  decimal point for active_digit
- blank  output  1  1 = active digit must be dark (the driver gates its anode)
- frame_done  output  1  one-cycle pulse at each frame wrap

## Operation

- Registers:
  - prescaler: width $clog2(REFRESH_DIV)
  - idx: 3 bits
  - committed image: value, dp_mask, digit_en, blank_lz
  - shadow image: same fields
  - pending flag
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
- On tick, idx advances. When idx == DIGITS-1, idx wraps to 0. Disabled digits are not skipped; they are blanked in their slot.
- Wrap event: tick with idx == DIGITS-1.
  - frame_done pulses high for exactly that cycle.
  - If pending = 1: committed <= shadow and pending <= 0.
- Handshake:
  - load_ready = !pending.
  - Transfer occurs when load_valid && load_ready. The shadow captures value, dp_mask, digit_en and blank_lz, and pending <= 1.
  - While pending = 1, load_valid is ignored. The requester must hold its data.
- Simultaneous transfer and wrap: pending was 0, so nothing commits. The new image goes to the shadow and commits at the next wrap.
- Output decode is a function of registered state only, with no combinational path from any input:
  - active_digit = idx.
  - num = committed nibble idx.
  - dp_ctrl = committed dp_mask[idx] && !blank.
  - blank = !committed digit_en[idx] OR (committed blank_lz AND idx != 0 AND committed nibbles idx..DIGITS-1 all zero).
  - Digit 0 is never lead-blanked, so a value of 0 shows as "0".
- Bits of value, dp_mask and digit_en above DIGITS are stored and ignored.

## Timing

- Reset values:
  - prescaler 0, idx 0, pending 0, all committed and shadow fields 0.
  - Outputs: active_digit 0, num 0, dp_ctrl 0, blank 1 (digit_en = 0), frame_done 0, load_ready 1.
- Reset has priority over tick and transfer. Reset mid-frame discards the pending image and restarts the scan at digit 0 with prescaler 0.
- idx changes on the edge where tick = 1. active_digit, num, dp_ctrl and blank change on that same edge.
- First tick after reset occurs REFRESH_DIV-1 cycles after reset deasserts.
- Frame period is DIGITS × REFRESH_DIV cycles. The first frame_done comes DIGITS×REFRESH_DIV−1 cycles after reset deasserts.
- Accept-to-display latency:
  - Minimum 1 cycle, when the transfer lands the cycle before a wrap.
  - Maximum DIGITS×REFRESH_DIV cycles.
- load_ready returns to 1 on the cycle after the commit.

## Test plan

Bench parameters: DIGITS=8, REFRESH_DIV=4 (32-cycle frame).

1. **Reset and scan.** Release reset with no load. Required: active_digit steps 0,1,…,7,0 every 4 cycles; blank = 1 throughout; frame_done pulses on cycles 31, 63, …
2. **Basic load.** Load value=0x12345678, digit_en=0xFF, dp_mask=0x04, blank_lz=0 at cycle 10. Required: load_ready drops at cycle 11; commit at cycle 31; in the following frame num reads 8,7,6,5,4,3,2,1; dp_ctrl = 1 only in slot 2; load_ready = 1 from cycle 32.
3. **Leading-zero blanking.** Load value=0x00000A05, blank_lz=1, digit_en=0xFF. Required: digits 0–2 unblanked (num 5,0,A); digits 3–7 blank = 1. Then load value=0, blank_lz=1. Required: only digit 0 is lit, num = 0.
4. **Back-pressure and collision.**
   - Hold load_valid with image A. Then present image B while pending. Required: B is ignored until load_ready = 1.
   - Assert load_valid exactly on a wrap cycle. Required: the image commits one frame later, not at that wrap.
5. **Digit enable.** digit_en=0x0F, dp_mask=0xFF. Required: slots 4–7 show blank = 1 and dp_ctrl = 0; slots 0–3 show dp_ctrl = 1.
6. **Reset mid-operation.** Assert reset at cycle 20 with an image pending. Required: after release, all outputs are at their reset values, load_ready = 1, and the old image never appears.

Source files
------------

// File: rtl/sseg_scan_scheduler.sv
// sseg_scan_scheduler: time-multiplexed scan controller for a seven-segment
// display. It holds a committed hex image and a shadow image. A new image is
// accepted through a valid/ready handshake and is swapped in only when the
// scan wraps, so each frame shows a single image.
// Ports:
//   clk, reset        - rising-edge clock and synchronous active-high reset
//   load_valid/ready  - image handshake (value, dp_mask, digit_en, blank_lz)
//   active_digit, num - scanned digit index and its nibble
//   dp_ctrl, blank    - decimal point and dark-digit control for that digit
//   frame_done        - one-cycle pulse on the cycle the scan wraps
module sseg_scan_scheduler #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        blank_lz,
  output logic [2:0]  active_digit,
  output logic [3:0]  num,
  output logic        dp_ctrl,
  output logic        blank,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        blz;
  } image_t;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  image_t        com;
  image_t        shadow;
  logic          pending;

  logic tick;
  logic wrap;
  logic xfer;
  logic upper_nz;

  assign tick = (presc == PMAX);
  assign wrap = tick && (idx == LAST);
  assign xfer = load_valid && !pending;

  // A commit needs pending = 1 and a transfer needs pending = 0, so the
  // two never happen on the same edge. An image accepted on a wrap cycle
  // waits in the shadow until the following wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      idx     <= 3'd0;
      com     <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
      end
      if (wrap && pending) begin
        com     <= shadow;
        pending <= 1'b0;
      end
      if (xfer) begin
        shadow  <= '{value, dp_mask, digit_en, blank_lz};
        pending <= 1'b1;
      end
    end
  end

  // The digit is a leading zero when it and every more-significant
  // scanned nibble are zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && com.value[4*i +: 4] != 4'h0) begin
        upper_nz = 1'b1;
      end
    end
  end

  assign active_digit = idx;
  assign num          = com.value[{idx, 2'b00} +: 4];
  assign blank        = !com.en[idx] ||
                        (com.blz && idx != 3'd0 && !upper_nz);
  assign dp_ctrl      = com.dp[idx] && !blank;
  assign frame_done   = wrap;
  assign load_ready   = !pending;

endmodule
